// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the stream FIFO slice.
// Default stream word width and a constant-evaluable clog2.
package stream_fifo_pkg;

  localparam int INT_N = 8;
  localparam int FIFO_DEPTH = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port,
// one asynchronous read port, contents never reset.
module stream_fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = INT_N,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Buffered valid/ready stream receiver with occupancy export.
// Pointers carry one extra wrap bit to tell full from empty.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = INT_N,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic [WIDTH-1:0] sIn,
  input  logic             sIn_valid,
  output logic             sIn_ready,
  output logic [WIDTH-1:0] sOut,
  output logic             sOut_valid,
  input  logic             sOut_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] WRAP = {1'b1, {AW{1'b0}}};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = ((wr_ptr ^ rd_ptr) == WRAP);
  assign sIn_ready  = !full;
  assign sOut_valid = !empty;
  assign push       = sIn_valid & sIn_ready;
  assign pop        = sOut_valid & sOut_ready;
  assign sOut       = empty ? '0 : rdata;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (sIn),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule
